// File: rtl/udp_rx_parser.sv
// Parses a GMII receive stream (Ethernet II / IPv4 / UDP), filters on local MAC/IP/port,
// streams the UDP payload and reports each accepted frame as good or bad via its FCS.
module udp_rx_parser #(
    parameter logic [47:0] LOCAL_MAC  = 48'h000A3501FEC0,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A80002,
    parameter logic [15:0] LOCAL_PORT = 16'd5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gmii_rxdv,
    input  logic [7:0]  gmii_rxd,
    output logic        payload_valid,
    output logic [7:0]  payload_data,
    output logic        pkt_done,
    output logic        pkt_err,
    output logic [47:0] exter_mac,
    output logic [31:0] exter_ip,
    output logic [15:0] exter_port,
    output logic [15:0] rx_data_len
);

    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TAIL, DROP
    } state_t;

    state_t      state, state_next;
    logic [15:0] cnt, cnt_next;
    logic [15:0] rem, rem_next;
    logic [39:0] sreg;
    logic [47:0] field;
    logic [31:0] crc;
    logic [47:0] sh_mac;
    logic [31:0] sh_ip;
    logic [15:0] sh_port;
    logic [15:0] sh_len;
    logic        crc_init, crc_run, emit;
    logic        cap_mac, cap_ip, cap_port, cap_len;
    logic        done_set, err_set;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Current byte appended to the previous five gives every multi-byte field on its last byte.
    assign field = {sreg, gmii_rxd};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            rem   <= rem_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rem_next   = rem;
        crc_init   = 1'b0;
        crc_run    = 1'b0;
        emit       = 1'b0;
        cap_mac    = 1'b0;
        cap_ip     = 1'b0;
        cap_port   = 1'b0;
        cap_len    = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        if (!gmii_rxdv) begin
            state_next = IDLE;
            cnt_next   = '0;
            if (state == TAIL) begin
                if (cnt >= 16'd4 && crc == CRC_RESIDUE) done_set = 1'b1;
                else                                    err_set  = 1'b1;
            end else if (state == PAYLOAD) begin
                err_set = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    cnt_next   = '0;
                    state_next = (gmii_rxd == 8'h55) ? PREAMBLE : DROP;
                end
                PREAMBLE: begin
                    if (gmii_rxd == 8'hD5) begin
                        state_next = ETH_HDR;
                        cnt_next   = '0;
                        crc_init   = 1'b1;
                    end else if (gmii_rxd == 8'h55 && cnt != 16'd7) begin
                        cnt_next = cnt + 16'd1;
                    end else begin
                        state_next = DROP;
                    end
                end
                ETH_HDR: begin
                    crc_run  = 1'b1;
                    cnt_next = cnt + 16'd1;
                    case (cnt)
                        16'd5:  if (field != LOCAL_MAC && field != '1) state_next = DROP;
                        16'd11: cap_mac = 1'b1;
                        16'd13: begin
                            if (field[15:0] == 16'h0800) begin
                                state_next = IP_HDR;
                                cnt_next   = '0;
                            end else begin
                                state_next = DROP;
                            end
                        end
                        default: ;
                    endcase
                end
                IP_HDR: begin
                    crc_run  = 1'b1;
                    cnt_next = cnt + 16'd1;
                    case (cnt)
                        16'd0:  if (field[7:0] != 8'h45) state_next = DROP;
                        16'd9:  if (field[7:0] != 8'h11) state_next = DROP;
                        16'd15: cap_ip = 1'b1;
                        16'd19: begin
                            if (field[31:0] == LOCAL_IP) begin
                                state_next = UDP_HDR;
                                cnt_next   = '0;
                            end else begin
                                state_next = DROP;
                            end
                        end
                        default: ;
                    endcase
                end
                UDP_HDR: begin
                    crc_run  = 1'b1;
                    cnt_next = cnt + 16'd1;
                    case (cnt)
                        16'd1: cap_port = 1'b1;
                        16'd3: if (field[15:0] != LOCAL_PORT) state_next = DROP;
                        16'd5: begin
                            if (field[15:0] < 16'd8) state_next = DROP;
                            else                     cap_len    = 1'b1;
                        end
                        16'd7: begin
                            cnt_next   = '0;
                            rem_next   = sh_len;
                            state_next = (sh_len == 16'd0) ? TAIL : PAYLOAD;
                        end
                        default: ;
                    endcase
                end
                PAYLOAD: begin
                    crc_run  = 1'b1;
                    emit     = 1'b1;
                    rem_next = rem - 16'd1;
                    if (rem == 16'd1) begin
                        state_next = TAIL;
                        cnt_next   = '0;
                    end
                end
                TAIL: begin
                    crc_run = 1'b1;
                    if (cnt != 16'hFFFF) cnt_next = cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Shadow fields only become visible on a verified frame, so a bad frame never disturbs them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg          <= '0;
            crc           <= '0;
            sh_mac        <= '0;
            sh_ip         <= '0;
            sh_port       <= '0;
            sh_len        <= '0;
            payload_valid <= 1'b0;
            payload_data  <= '0;
            pkt_done      <= 1'b0;
            pkt_err       <= 1'b0;
            exter_mac     <= '0;
            exter_ip      <= '0;
            exter_port    <= '0;
            rx_data_len   <= '0;
        end else begin
            if (gmii_rxdv) sreg <= field[39:0];
            if (crc_init)     crc <= '1;
            else if (crc_run) crc <= crc_byte(crc, gmii_rxd);
            if (cap_mac)  sh_mac  <= field;
            if (cap_ip)   sh_ip   <= field[31:0];
            if (cap_port) sh_port <= field[15:0];
            if (cap_len)  sh_len  <= field[15:0] - 16'd8;
            payload_valid <= emit;
            if (emit) payload_data <= gmii_rxd;
            pkt_done <= done_set;
            pkt_err  <= err_set;
            if (done_set) begin
                exter_mac   <= sh_mac;
                exter_ip    <= sh_ip;
                exter_port  <= sh_port;
                rx_data_len <= sh_len;
            end
        end
    end

endmodule

// File: tb/tb_udp_rx_parser.sv
// Self-checking bench for udp_rx_parser: a frame-level model predicts payload, verdict and
// published fields, and a per-cycle compare process checks the DUT against it.
module tb_udp_rx_parser;

    localparam logic [47:0] LOCAL_MAC  = 48'h000A3501FEC0;
    localparam logic [31:0] LOCAL_IP   = 32'hC0A80002;
    localparam logic [15:0] LOCAL_PORT = 16'd5000;
    localparam logic [47:0] SRC_MAC    = 48'h001122334455;
    localparam logic [31:0] SRC_IP     = 32'hC0A80003;
    localparam logic [15:0] SRC_PORT   = 16'd6102;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gmii_rxdv;
    logic [7:0]  gmii_rxd;
    logic        payload_valid;
    logic [7:0]  payload_data;
    logic        pkt_done;
    logic        pkt_err;
    logic [47:0] exter_mac;
    logic [31:0] exter_ip;
    logic [15:0] exter_port;
    logic [15:0] rx_data_len;

    udp_rx_parser dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .gmii_rxdv     (gmii_rxdv),
        .gmii_rxd      (gmii_rxd),
        .payload_valid (payload_valid),
        .payload_data  (payload_data),
        .pkt_done      (pkt_done),
        .pkt_err       (pkt_err),
        .exter_mac     (exter_mac),
        .exter_ip      (exter_ip),
        .exter_port    (exter_port),
        .rx_data_len   (rx_data_len)
    );

    always #4 clk = ~clk;

    typedef enum int {V_NONE, V_DONE, V_ERR} verdict_e;
    typedef struct {
        verdict_e     kind;
        logic [111:0] pub;
    } verdict_t;

    logic [7:0] frame[$];
    logic [7:0] exp_pay[$];
    verdict_t   exp_verdict[$];

    int check_cnt  = 0;
    int pass_cnt   = 0;
    int strobe_cnt = 0;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        check_cnt++;
        if (act !== exp) $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        else             pass_cnt++;
    endtask

    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] r;
        r = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            r = r ^ {24'd0, frame[i]};
            for (int b = 0; b < 8; b++)
                r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return ~r;
    endfunction

    function automatic logic [47:0] be(input int off, input int len);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < len; i++) r = {r[39:0], frame[off+i]};
        return r;
    endfunction

    task automatic push_be(input logic [47:0] v, input int len);
        for (int i = len - 1; i >= 0; i--) frame.push_back(v[i*8 +: 8]);
    endtask

    task automatic build_frame(input logic [47:0] dmac, input logic [31:0] dip,
                               input logic [15:0] dport, input int plen, input int pad,
                               input bit flip);
        logic [31:0] fcs;
        frame.delete();
        push_be(dmac, 6);
        push_be(SRC_MAC, 6);
        push_be(48'h0800, 2);
        push_be(48'h4500, 2);
        push_be(48'(28 + plen), 2);
        push_be(48'h0000_4000, 4);
        push_be(48'h4011, 2);
        push_be(48'h0000, 2);
        push_be({16'd0, SRC_IP}, 4);
        push_be({16'd0, dip}, 4);
        push_be({32'd0, SRC_PORT}, 2);
        push_be({32'd0, dport}, 2);
        push_be(48'(plen + 8), 2);
        push_be(48'h0000, 2);
        for (int i = 0; i < plen; i++) frame.push_back(8'(i));
        for (int i = 0; i < pad; i++) frame.push_back(8'h00);
        fcs = fcs_of(frame.size());
        for (int i = 0; i < 4; i++) frame.push_back(fcs[i*8 +: 8]);
        if (flip) frame[frame.size()-4] = frame[frame.size()-4] ^ 8'h01;
    endtask

    // Expected result when the first n bytes of the current frame are delivered after the SFD.
    task automatic model_frame(input int n);
        verdict_t    v;
        logic [47:0] dmac, tmp;
        logic [15:0] ulen, dport;
        logic [31:0] dip, fcs;
        int          plen, avail, take;
        bit          ok;
        v.kind = V_NONE;
        v.pub  = '0;
        if (n >= 42) begin
            dmac  = be(0, 6);
            tmp   = be(30, 4);  dip   = tmp[31:0];
            tmp   = be(36, 2);  dport = tmp[15:0];
            tmp   = be(38, 2);  ulen  = tmp[15:0];
            ok = (dmac == LOCAL_MAC || dmac == 48'hFFFFFFFFFFFF) && frame[12] == 8'h08 &&
                 frame[13] == 8'h00 && frame[14] == 8'h45 && frame[23] == 8'h11 &&
                 dip == LOCAL_IP && dport == LOCAL_PORT && ulen >= 16'd8;
            if (ok) begin
                plen  = int'(ulen) - 8;
                avail = n - 42;
                take  = (avail < plen) ? avail : plen;
                for (int i = 0; i < take; i++) exp_pay.push_back(frame[42+i]);
                if (avail < plen || avail - plen < 4) begin
                    v.kind = V_ERR;
                end else begin
                    fcs = fcs_of(n - 4);
                    v.kind = ({frame[n-1], frame[n-2], frame[n-3], frame[n-4]} == fcs) ? V_DONE : V_ERR;
                end
                v.pub = {be(6, 6), SRC_IP, SRC_PORT, 16'(plen)};
                tmp = be(26, 4);
                v.pub[63:32] = tmp[31:0];
                tmp = be(34, 2);
                v.pub[31:16] = tmp[15:0];
            end
        end
        exp_verdict.push_back(v);
    endtask

    // Sends preamble+SFD and the first n frame bytes; rst_at >= 0 pulses reset mid-frame.
    task automatic applyStimulus(input int n, input int gap, input int rst_at);
        verdict_t v;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            gmii_rxdv = 1'b1;
            gmii_rxd  = (i == 7) ? 8'hD5 : 8'h55;
            if (i == 0) begin
                if (rst_at < 0) model_frame(n);
                else begin
                    v.kind = V_NONE;
                    v.pub  = '0;
                    exp_verdict.push_back(v);
                end
            end
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (rst_at >= 0 && i == rst_at)     rst_n = 1'b0;
            if (rst_at >= 0 && i == rst_at + 2) rst_n = 1'b1;
            gmii_rxd = frame[i];
        end
        @(posedge clk); #1;
        gmii_rxdv = 1'b0;
        gmii_rxd  = 8'h00;
        repeat (gap - 1) @(posedge clk);
        #1;
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    logic [111:0] exp_pub = '0;
    verdict_t     pending;
    logic         prev_rxdv = 1'b0;
    logic [7:0]   exp_byte;

    initial begin
        pending.kind = V_NONE;
        pending.pub  = '0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pub      = '0;
            pending.kind = V_NONE;
            checkOutput("reset_outputs",
                        {payload_valid, payload_data, pkt_done, pkt_err,
                         exter_mac, exter_ip, exter_port, rx_data_len}, '0);
        end else begin
            if (payload_valid) begin
                strobe_cnt++;
                if (exp_pay.size() == 0) begin
                    checkOutput("unexpected_payload", {1'b1, payload_data}, '0);
                end else begin
                    exp_byte = exp_pay.pop_front();
                    checkOutput("payload_byte", payload_data, exp_byte);
                end
            end
            if (pending.kind == V_DONE) exp_pub = pending.pub;
            checkOutput("pkt_done", pkt_done, pending.kind == V_DONE);
            checkOutput("pkt_err", pkt_err, pending.kind == V_ERR);
            checkOutput("published", {exter_mac, exter_ip, exter_port, rx_data_len}, exp_pub);
            pending.kind = V_NONE;
            if (prev_rxdv && !gmii_rxdv) begin
                if (exp_verdict.size() == 0) checkOutput("verdict_queue", 1, 0);
                else pending = exp_verdict.pop_front();
                checkOutput("payload_remaining", exp_pay.size(), 0);
            end
        end
        prev_rxdv = gmii_rxdv;
    end

    initial begin
        rst_n     = 1'b0;
        gmii_rxdv = 1'b0;
        gmii_rxd  = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("reset_state",
                    {payload_valid, payload_data, pkt_done, pkt_err,
                     exter_mac, exter_ip, exter_port, rx_data_len}, '0);

        $display("[TB] valid frame, 18 payload bytes");
        strobe_cnt = 0;
        build_frame(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 18, 0, 1'b0);
        applyStimulus(frame.size(), 4, -1);
        checkOutput("t1_strobes", strobe_cnt, 18);
        checkOutput("t1_len", rx_data_len, 16'd18);
        checkOutput("t1_ip", exter_ip, 32'hC0A80003);
        checkOutput("t1_port", exter_port, 16'd6102);
        checkOutput("t1_mac", exter_mac, 48'h001122334455);

        $display("[TB] broadcast frame, 4 payload bytes, 24 pad bytes");
        strobe_cnt = 0;
        build_frame(48'hFFFFFFFFFFFF, LOCAL_IP, LOCAL_PORT, 4, 24, 1'b0);
        applyStimulus(frame.size(), 4, -1);
        checkOutput("t2_strobes", strobe_cnt, 4);
        checkOutput("t2_len", rx_data_len, 16'd4);

        $display("[TB] filtered frames");
        strobe_cnt = 0;
        build_frame(LOCAL_MAC, LOCAL_IP, 16'd5001, 18, 0, 1'b0);
        applyStimulus(frame.size(), 4, -1);
        build_frame(LOCAL_MAC, 32'hC0A80009, LOCAL_PORT, 18, 0, 1'b0);
        applyStimulus(frame.size(), 4, -1);
        checkOutput("t3_strobes", strobe_cnt, 0);
        checkOutput("t3_len_held", rx_data_len, 16'd4);
        checkOutput("t3_mac_held", exter_mac, 48'h001122334455);

        $display("[TB] bad FCS");
        strobe_cnt = 0;
        build_frame(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 18, 0, 1'b1);
        applyStimulus(frame.size(), 4, -1);
        checkOutput("t4_strobes", strobe_cnt, 18);
        checkOutput("t4_len_held", rx_data_len, 16'd4);

        $display("[TB] truncated payload then back-to-back good frame");
        strobe_cnt = 0;
        build_frame(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 18, 0, 1'b0);
        applyStimulus(52, 1, -1);
        build_frame(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 18, 0, 1'b0);
        applyStimulus(frame.size(), 4, -1);
        checkOutput("t5_strobes", strobe_cnt, 28);
        checkOutput("t5_len", rx_data_len, 16'd18);

        $display("[TB] reset during IP header");
        strobe_cnt = 0;
        build_frame(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 18, 0, 1'b0);
        applyStimulus(frame.size(), 4, 20);
        checkOutput("t6_strobes", strobe_cnt, 0);
        checkOutput("t6_cleared", {exter_mac, exter_ip, exter_port, rx_data_len}, '0);
        build_frame(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 18, 0, 1'b0);
        applyStimulus(frame.size(), 4, -1);
        checkOutput("t6_len", rx_data_len, 16'd18);
        checkOutput("t6_ip", exter_ip, 32'hC0A80003);

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/udp_rx_parser.md
Name: udp_rx_parser

Overview:
Receive-side counterpart of the UDP transmit path. Parses an 8-bit GMII receive stream (Ethernet II / IPv4 / UDP), filters on local MAC/IP/port, and streams UDP payload bytes out. Checks FCS with CRC-32 and reports each frame as good (pkt_done) or bad (pkt_err). Sits between the RGMII-to-GMII converter and the loopback FIFO. Its remote MAC/IP/port and length outputs feed the UDP transmitter.

Parameters:
LOCAL_MAC, 48'h000A3501FEC0, accepted destination MAC; broadcast FF:FF:FF:FF:FF:FF is also accepted.
LOCAL_IP, 32'hC0A80002, accepted destination IPv4 address.
LOCAL_PORT, 16'd5000, accepted destination UDP port.

Ports:
clk  in  1  GMII receive clock, 125 MHz
rst_n  in  1  asynchronous active-low reset
gmii_rxdv  in  1  receive data valid
gmii_rxd  in  8  receive byte
payload_valid  out  1  payload byte strobe
payload_data  out  8  payload byte
pkt_done  out  1  1-cycle pulse: accepted frame with good FCS
pkt_err  out  1  1-cycle pulse: accepted frame, bad FCS or truncated
exter_mac  out  48  source MAC of last good frame
exter_ip  out  32  source IP of last good frame
exter_port  out  16  source UDP port of last good frame
rx_data_len  out  16  UDP payload length of last good frame (UDP length − 8)

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All logic is in the clk domain.
- Reset values: every output is 0. The FSM is in IDLE.
- States: IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TAIL, DROP.
- IDLE: on rxdv=1 with rxd=0x55, go to PREAMBLE. On any other rxdv=1 byte, go to DROP.
- PREAMBLE: 1 to 7 further 0x55 bytes are accepted. 0xD5 goes to ETH_HDR and resets the byte counter. Any other byte, or an 8th 0x55, goes to DROP.
- ETH_HDR (14 bytes), big-endian capture:
  - Destination MAC must equal LOCAL_MAC or broadcast.
  - EtherType must be 0x0800.
  - Source MAC is captured into a shadow register.
- IP_HDR (20 bytes):
  - Byte 0 must be 0x45; options are unsupported, so any other value goes to DROP.
  - Byte 9 (protocol) must be 0x11.
  - Bytes 12–15 (source IP) go to shadow. Bytes 16–19 (destination IP) must equal LOCAL_IP.
  - The IP header checksum is not checked.
- UDP_HDR (8 bytes):
  - Source port goes to shadow. Destination port must equal LOCAL_PORT.
  - The length field is captured. Length < 8 goes to DROP.
  - Payload count = length − 8. A count of 0 goes directly to TAIL.
- Any mismatch goes to DROP at the byte that fails. The check is made on the last byte of each field.
- PAYLOAD: each byte is presented on payload_data with payload_valid=1, one clk after it appears on gmii_rxd (registered). Exactly count bytes are output, then go to TAIL.
- TAIL: Ethernet padding and the 4 FCS bytes are consumed. Nothing is output. At least 4 bytes must arrive in TAIL.
- CRC:
  - CRC-32, polynomial 0x04C11DB7, reflected (LSB-first), initialised to 0xFFFFFFFF at SFD.
  - Runs over every byte from the first destination-MAC byte through the last FCS byte.
  - The frame is good iff the register equals residue 0xDEBB20E3 when rxdv falls.
- End of frame (rxdv 1→0), one cycle after the last byte:
  - In TAIL with ≥4 bytes and good CRC: pkt_done=1 for 1 cycle. In the same cycle, exter_mac/ip/port and rx_data_len load from shadow.
  - In TAIL with bad CRC or fewer than 4 bytes: pkt_err=1 for 1 cycle.
  - In PAYLOAD: pkt_err=1 for 1 cycle (truncated frame).
  - In PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR or DROP: return to IDLE silently; no pulse and no output update.
- pkt_done and pkt_err are never asserted together. Published outputs change only on pkt_done.
- Payload bytes are emitted before the FCS verdict. Downstream must commit on pkt_done or discard on pkt_err.
- DROP: ignore bytes until rxdv=0, then go to IDLE.
- After any end-of-frame, a new frame may start on the very next rxdv=1 cycle.
- Reset mid-frame: immediate return to IDLE, outputs cleared, shadow registers cleared, no pulse. The remainder of the frame is then handled from IDLE, so a non-0x55 byte sends it to DROP.
- Counters: 16-bit byte counter inside each header state and for payload. A payload length up to 65527 is supported without wrap.

Test Plan:
1. Valid frame: dst=LOCAL_MAC, src MAC 00:11:22:33:44:55, src IP C0A80003, src port 6102, dst port 5000, UDP length 26 (18 payload bytes 0x00..0x11), 0 pad bytes (ETH+IP+UDP+payload = 60), correct FCS -> exactly 18 payload_valid strobes carrying 0x00..0x11 in order; pkt_done 1 cycle after rxdv falls; rx_data_len=18, exter_ip=C0A80003, exter_port=6102, exter_mac=001122334455.
2. Same frame with dst MAC FFFFFFFFFFFF and a 4-byte payload, followed by 24 pad bytes -> 4 strobes; padding not emitted; pkt_done; rx_data_len=4.
3. Destination port 5001, or destination IP C0A80009 -> no payload_valid, no pkt_done, no pkt_err; outputs hold previous values.
4. Test 1 with one FCS bit flipped -> 18 strobes, then pkt_err pulse; pkt_done stays 0; exter_* unchanged.
5. rxdv dropped after 10 of 18 payload bytes -> 10 strobes, then pkt_err; the next valid frame, sent back-to-back, gives pkt_done.
6. rst_n asserted during IP_HDR, released while the frame continues -> no pulse and all outputs 0; the following valid frame is received correctly.
